// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared source modes and sequencer state encoding
package reset_seq_pkg;

    localparam logic [1:0] MODE_LEVEL = 2'b00;
    localparam logic [1:0] MODE_RISE  = 2'b01;
    localparam logic [1:0] MODE_FALL  = 2'b10;
    localparam logic [1:0] MODE_OFF   = 2'b11;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'b00,
        ST_STRETCH = 2'b01,
        ST_RELEASE = 2'b10,
        ST_RUN     = 2'b11
    } state_t;

    // Idle (non-requesting) level of a source; falling-edge sources idle high.
    function automatic logic mode_idle(input logic [1:0] mode);
        return (mode == MODE_FALL);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - request inputs and sequenced reset outputs
interface reset_sequencer_if #(
    parameter int NUM_SRC = 2,
    parameter int NUM_OUT = 2
);
    logic               pll_locked;
    logic [NUM_SRC-1:0] req_in;
    logic               cause_clr;
    logic [NUM_OUT-1:0] rst_out;
    logic               rst_busy;
    logic [NUM_SRC:0]   cause;

    modport master (
        output pll_locked, req_in, cause_clr,
        input  rst_out, rst_busy, cause
    );

    modport slave (
        input  pll_locked, req_in, cause_clr,
        output rst_out, rst_busy, cause
    );
endinterface

// File: rtl/reset_src_filter.sv
// rtl/reset_src_filter.sv - per-source synchroniser, debounce and edge detect
module reset_src_filter
    import reset_seq_pkg::*;
#(
    parameter logic [1:0] MODE            = MODE_FALL,
    parameter int         SYNC_STAGES     = 2,
    parameter int         DEBOUNCE_CYCLES = 4
) (
    input  logic CLK,
    input  logic reset_in,
    input  logic din,
    output logic filt,
    output logic trig
);
    localparam logic            INIT     = mode_idle(MODE);
    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             synced;
    logic [CNT_W-1:0] cnt;
    logic             update;

    reset_sync_chain #(
        .STAGES (SYNC_STAGES),
        .INIT   (INIT)
    ) u_sync (
        .CLK      (CLK),
        .reset_in (reset_in),
        .din      (din),
        .dout     (synced)
    );

    assign update = (synced != filt) && (cnt == CNT_LAST);

    // Any cycle where synced agrees with filt restarts the stability count.
    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            filt <= INIT;
            cnt  <= '0;
        end else if (synced == filt) begin
            cnt <= '0;
        end else if (update) begin
            filt <= synced;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        trig = 1'b0;
        if (update) begin
            case (MODE)
                MODE_LEVEL, MODE_RISE: trig = synced;
                MODE_FALL:             trig = ~synced;
                default:               trig = 1'b0;
            endcase
        end
    end
endmodule

// File: rtl/reset_sync_chain.sv
// rtl/reset_sync_chain.sv - multi-flop synchroniser with configurable reset value
module reset_sync_chain #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic CLK,
    input  logic reset_in,
    input  logic din,
    output logic dout
);
    logic [STAGES-1:0] q;

    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            q <= {STAGES{INIT}};
        end else begin
            q <= {q[STAGES-2:0], din};
        end
    end

    assign dout = q[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - multi-source reset controller with stretched, ordered release
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int                   NUM_SRC         = 2,
    parameter int                   NUM_OUT         = 2,
    parameter int                   SYNC_STAGES     = 2,
    parameter int                   DEBOUNCE_CYCLES = 4,
    parameter int                   STRETCH_CYCLES  = 255,
    parameter int                   STAGE_GAP       = 16,
    parameter logic [2*NUM_SRC-1:0] SRC_MODE        = {2'b10, 2'b10}
) (
    input  logic              CLK,
    input  logic              reset_in,
    reset_sequencer_if.slave  bus
);
    localparam int STR_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES + 1) : 1;
    localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP + 1) : 1;
    localparam int STG_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [STR_W-1:0] STR_LAST = STR_W'(STRETCH_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);

    logic [NUM_SRC-1:0] trig;
    logic [NUM_SRC-1:0] filt;
    logic [NUM_SRC-1:0] level_mask;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        localparam logic [1:0] MODE = SRC_MODE[2*i +: 2];
        assign level_mask[i] = (MODE == MODE_LEVEL);

        reset_src_filter #(
            .MODE            (MODE),
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_filter (
            .CLK      (CLK),
            .reset_in (reset_in),
            .din      (bus.req_in[i]),
            .filt     (filt[i]),
            .trig     (trig[i])
        );
    end

    logic pll_sync;
    logic pll_prev;
    logic pll_fall;

    reset_sync_chain #(
        .STAGES (SYNC_STAGES),
        .INIT   (1'b0)
    ) u_pll_sync (
        .CLK      (CLK),
        .reset_in (reset_in),
        .din      (bus.pll_locked),
        .dout     (pll_sync)
    );

    assign pll_fall = pll_prev & ~pll_sync;

    logic restart;
    logic hold;
    assign restart = (|trig) | pll_fall;
    assign hold    = (|(filt & level_mask)) | ~pll_sync;

    state_t           state, state_n;
    logic [STR_W-1:0] str_cnt, str_cnt_n;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
    logic [STG_W-1:0] stage, stage_n;

    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            state    <= ST_ASSERT;
            str_cnt  <= '0;
            gap_cnt  <= '0;
            stage    <= '0;
            pll_prev <= 1'b0;
        end else begin
            state    <= state_n;
            str_cnt  <= str_cnt_n;
            gap_cnt  <= gap_cnt_n;
            stage    <= stage_n;
            pll_prev <= pll_sync;
        end
    end

    always_comb begin
        state_n   = state;
        str_cnt_n = str_cnt;
        gap_cnt_n = gap_cnt;
        stage_n   = stage;
        if (restart) begin
            state_n   = ST_ASSERT;
            str_cnt_n = '0;
            gap_cnt_n = '0;
            stage_n   = '0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    str_cnt_n = '0;
                    gap_cnt_n = '0;
                    stage_n   = '0;
                    if (!hold) begin
                        state_n = ST_STRETCH;
                    end
                end
                ST_STRETCH: begin
                    if (str_cnt == STR_LAST) begin
                        state_n   = ST_RELEASE;
                        gap_cnt_n = '0;
                        stage_n   = '0;
                    end else begin
                        str_cnt_n = str_cnt + STR_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // stage k means outputs 0..k are already released
                    if (int'(stage) + 1 >= NUM_OUT) begin
                        state_n = ST_RUN;
                    end else if (gap_cnt == GAP_LAST) begin
                        gap_cnt_n = '0;
                        if (int'(stage) + 2 >= NUM_OUT) begin
                            state_n = ST_RUN;
                        end else begin
                            stage_n = stage + STG_W'(1);
                        end
                    end else begin
                        gap_cnt_n = gap_cnt + GAP_W'(1);
                    end
                end
                ST_RUN: begin
                    state_n = ST_RUN;
                end
                default: begin
                    state_n = ST_ASSERT;
                end
            endcase
        end
    end

    logic [NUM_OUT-1:0] rst_n;
    logic [NUM_OUT-1:0] rst_q;
    logic               busy_q;
    logic [NUM_SRC:0]   cause_q;
    logic [NUM_SRC:0]   cause_n;

    always_comb begin
        rst_n = '1;
        if (state == ST_RUN) begin
            rst_n = '0;
        end else if (state == ST_RELEASE) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (k <= int'(stage)) begin
                    rst_n[k] = 1'b0;
                end
            end
        end
    end

    // A new event in the same cycle as a clear must still be recorded.
    assign cause_n = (bus.cause_clr ? '0 : cause_q) | {pll_fall, trig};

    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            rst_q   <= '1;
            busy_q  <= 1'b1;
            cause_q <= '0;
        end else begin
            rst_q   <= rst_n;
            busy_q  <= (state != ST_RUN);
            cause_q <= cause_n;
        end
    end

    assign bus.rst_out  = rst_q;
    assign bus.rst_busy = busy_q;
    assign bus.cause    = cause_q;
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised reset controller for the Murax/BlackIce top level. It replaces the fixed PLL-lock counter and single GRESET falling-edge synchroniser with NUM_SRC configurable reset request sources, each with synchroniser, debounce and per-source edge/level mode. It stretches reset, then releases NUM_OUT reset outputs in a fixed order with a programmable gap between them. A sticky cause register records which source fired.

Parameters:
NUM_SRC, 2, number of external reset request inputs
NUM_OUT, 2, number of sequenced reset outputs; released in index order 0 first
SYNC_STAGES, 2, synchroniser flops per async input (>=2)
DEBOUNCE_CYCLES, 4, consecutive stable synced cycles needed to change a filtered input (>=1)
STRETCH_CYCLES, 255, minimum cycles in STRETCH before release begins (>=1)
STAGE_GAP, 16, cycles between successive output deassertions (>=1)
SRC_MODE, {2'b10,2'b10}, 2 bits per source: 00 level-high, 01 rising edge, 10 falling edge, 11 disabled

Ports:
CLK  input  1  system clock
reset_in  input  1  asynchronous, active-high reset
pll_locked  input  1  async PLL lock indication
req_in  input  NUM_SRC  async reset requests
cause_clr  input  1  sync pulse, clears cause
rst_out  output  NUM_OUT  active-high resets to downstream blocks
rst_busy  output  1  high whenever state != RUN
cause  output  NUM_SRC+1  sticky: bit i = source i fired, bit NUM_SRC = PLL lock lost

Behaviour:
- reset_in high (async): state=ASSERT, rst_out all ones, rst_busy=1, cause=0, all counters 0. Synchroniser and filter flops of a source take that mode's inactive value: 1 for falling mode, 0 otherwise. pll sync flops take 0.
- Synchronisation: req_in[i] and pll_locked each pass through SYNC_STAGES flops. pll_locked has no debounce.
- Debounce: filt[i] takes the synced value only after it has differed from filt[i] for DEBOUNCE_CYCLES consecutive cycles. Any mismatch break restarts the count.
- Trigger[i] is a 1-cycle pulse in the cycle filt[i] updates:
  - level mode: filt 0->1
  - rising mode: filt 0->1
  - falling mode: filt 1->0
  - disabled: never triggers
- Hold conditions: a level-mode source with filt=1, or pll_sync=0, holds the FSM in ASSERT.
- Latency: from the first edge sampling an active req_in, rst_out goes all ones at edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
- FSM:
  - ASSERT -> STRETCH when no hold and no trigger.
  - STRETCH: counter runs 0..STRETCH_CYCLES-1, then -> RELEASE.
  - RELEASE: clears rst_out[0] on entry. Then clears rst_out[k] STAGE_GAP cycles after rst_out[k-1]. After clearing rst_out[NUM_OUT-1], -> RUN.
  - RUN: all outputs 0.
  - Any trigger or pll_sync falling, in any state: -> ASSERT at the next edge, all rst_out=1, counters cleared. This is a restart even mid-STRETCH or mid-RELEASE.
- rst_out and rst_busy are registered, with no combinational paths from inputs.
- cause:
  - bit i set on trigger[i].
  - bit NUM_SRC set on pll_sync 1->0.
  - cause_clr clears all bits.
  - Same-cycle set and clear: set wins for that bit.
  - cause is not cleared by sequencing, only by reset_in or cause_clr. cause==0 after a completed sequence means power-on.
- Counters are sized $clog2(max+1). No wrap: each counter saturates or stops at its terminal value.

Decomposition:
- Package reset_seq_pkg holds:
  - mode localparams MODE_LEVEL/MODE_RISE/MODE_FALL/MODE_OFF
  - FSM state encoding ST_ASSERT/ST_STRETCH/ST_RELEASE/ST_RUN
- Sub-module reset_src_filter (sync + debounce + edge detect, MODE and DEBOUNCE_CYCLES params, outputs filt and trig). Instantiated per source via generate.
- pll_locked uses the same sync chain with no filter.

Test Plan:
- POR, defaults, pll_locked=1, req_in=2'b11:
  - release reset_in.
  - rst_out[0] falls exactly SYNC_STAGES+STRETCH_CYCLES+2 edges later.
  - rst_out[1] falls exactly 16 cycles after rst_out[0].
  - rst_busy falls with rst_out[1].
  - cause==0.
- GRESET-style falling pulse on req_in[0] held low 10 cycles while in RUN:
  - rst_out=2'b11 at edge 7 after the fall (2+4+1).
  - full sequence repeats.
  - cause==3'b001.
- Glitch rejection: req_in[1] low for 3 cycles -> no trigger, rst_out stays 0, cause unchanged. Then low for 4 cycles -> trigger.
- Restart mid-RELEASE: trigger source 0 eight cycles after rst_out[0] falls -> rst_out=2'b11 and STRETCH restarts from 0.
- PLL loss: drop pll_locked for 50 cycles in RUN:
  - outputs held at 11 while low.
  - cause[2]=1.
  - release starts STRETCH_CYCLES after pll_sync returns high.
- Cause clear collision: cause_clr asserted in the same cycle as trigger[1] -> cause[1]=1 and other bits 0. Level mode (SRC_MODE=00) held high holds ASSERT indefinitely.
